// File: rtl/sine_voice_scheduler.sv
// Multi-voice sine generator: one shared registered sine LUT is time-multiplexed
// across NUM_VOICES phase accumulators, and the voices are summed into one sample.
`timescale 1ns/1ps

module sine_lut (
    input  logic       clk_in,
    input  logic [5:0] addr,
    output logic [7:0] data
);
    // floor(128 + 127.5*sin(2*pi*i/64)), offset-binary
    localparam logic [7:0] SINE_TABLE [64] = '{
        8'h80, 8'h8C, 8'h98, 8'hA5, 8'hB0, 8'hBC, 8'hC6, 8'hD0,
        8'hDA, 8'hE2, 8'hEA, 8'hF0, 8'hF5, 8'hFA, 8'hFD, 8'hFE,
        8'hFF, 8'hFE, 8'hFD, 8'hFA, 8'hF5, 8'hF0, 8'hEA, 8'hE2,
        8'hDA, 8'hD0, 8'hC6, 8'hBC, 8'hB0, 8'hA5, 8'h98, 8'h8C,
        8'h80, 8'h73, 8'h67, 8'h5A, 8'h4F, 8'h43, 8'h39, 8'h2F,
        8'h25, 8'h1D, 8'h15, 8'h0F, 8'h0A, 8'h05, 8'h02, 8'h01,
        8'h00, 8'h01, 8'h02, 8'h05, 8'h0A, 8'h0F, 8'h15, 8'h1D,
        8'h25, 8'h2F, 8'h39, 8'h43, 8'h4F, 8'h5A, 8'h67, 8'h73
    };

    always_ff @(posedge clk_in) begin
        data <= SINE_TABLE[addr];
    end
endmodule

module sine_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = $clog2(NUM_VOICES),
    parameter int OUT_W      = 8 + IDX_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             step_in,
    input  logic             cfg_we_in,
    input  logic [IDX_W-1:0] cfg_addr_in,
    input  logic [31:0]      cfg_incr_in,
    input  logic             cfg_en_in,
    input  logic             cfg_clr_in,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid_out,
    output logic             busy_out,
    output logic             overrun_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           phase [NUM_VOICES];
    logic [31:0]           incr  [NUM_VOICES];
    logic [NUM_VOICES-1:0] en;
    logic [OUT_W-1:0]      acc;
    logic                  tag;
    logic                  issue_vld;
    logic [5:0]            lut_addr;
    logic [7:0]            lut_data;
    logic signed [7:0]     amp;

    assign lut_addr = phase[idx][31:26];
    assign amp      = {~lut_data[7], lut_data[6:0]};

    sine_lut u_lut (
        .clk_in (clk_in),
        .addr   (lut_addr),
        .data   (lut_data)
    );

    // busy_out stays high through the valid-pulse cycle, so steps arriving then are overruns
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            idx              <= '0;
            acc              <= '0;
            tag              <= 1'b0;
            issue_vld        <= 1'b0;
            en               <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            overrun_out      <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v] <= '0;
                incr[v]  <= '0;
            end
        end else begin
            sample_valid_out <= 1'b0;
            issue_vld        <= (state == ISSUE);
            tag              <= en[idx];

            if (issue_vld && tag)
                acc <= acc + {{(OUT_W-8){amp[7]}}, amp};

            if (step_in && busy_out)
                overrun_out <= 1'b1;

            case (state)
                IDLE: begin
                    if (busy_out) begin
                        busy_out <= 1'b0;
                    end else if (step_in) begin
                        state    <= ISSUE;
                        idx      <= '0;
                        acc      <= '0;
                        busy_out <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (en[idx])
                        phase[idx] <= phase[idx] + incr[idx];
                    if (idx == IDX_W'(NUM_VOICES - 1))
                        state <= DRAIN;
                    else
                        idx <= idx + 1'b1;
                end
                DRAIN: begin
                    state <= DONE;
                end
                DONE: begin
                    sample_out       <= acc;
                    sample_valid_out <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Placed after the sequencer so a clear wins over the same-cycle increment
            if (cfg_we_in) begin
                incr[cfg_addr_in] <= cfg_incr_in;
                en[cfg_addr_in]   <= cfg_en_in;
                if (cfg_clr_in)
                    phase[cfg_addr_in] <= '0;
            end
        end
    end
endmodule

// File: doc/sine_voice_scheduler.md
Name: sine_voice_scheduler

Overview:
Time-multiplexes one registered 64-entry sine LUT (sine_lut, 6-bit phase in, 8-bit offset-binary out, 1-cycle read latency) across NUM_VOICES phase accumulators. On each sample tick it sequences every voice through the shared LUT and advances each enabled voice's phase. It sums the signed amplitudes into one mixed sample. A small config port sets each voice's phase increment and enable. The block sits between the sample-rate tick generator and the audio output path. It replaces one sine generator instance per tone.

Parameters:
NUM_VOICES, 4, number of voices; power of two, 2..16
IDX_W, $clog2(NUM_VOICES), voice index width
OUT_W, 8+IDX_W, mixed sample width; the sum cannot overflow

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-low reset (0 = reset)
step_in  input  1  sample tick, one-cycle pulse
cfg_we_in  input  1  config write strobe
cfg_addr_in  input  IDX_W  voice to configure
cfg_incr_in  input  32  phase increment for that voice
cfg_en_in  input  1  voice enable
cfg_clr_in  input  1  on write, zero the voice's phase
sample_out  output  OUT_W  signed mixed sample (2's complement)
sample_valid_out  output  1  one-cycle pulse when sample_out updates
busy_out  output  1  high while a tick is being processed
overrun_out  output  1  sticky; a step_in arrived while busy

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - All phase, incr and en registers go to 0.
  - State goes to IDLE.
  - sample_out, sample_valid_out, busy_out and overrun_out all go to 0.
  - Reset mid-sequence aborts the sequence; no valid pulse follows.
- Per-voice state: phase[32], incr[32], en[1].
- Voice k uses phase[k][31:26] as its LUT address.
- LUT output conversion: amplitude = {~lut[7], lut[6:0]}, taken as signed 8-bit.
- State machine:
  - IDLE: if step_in=1, go to ISSUE with idx=0 and clear the accumulator. Otherwise stay.
  - ISSUE (NUM_VOICES cycles, idx = 0..N-1):
    - Drive the LUT address from phase[idx], using the value before this cycle's update.
    - If en[idx]=1, phase[idx] <= phase[idx] + incr[idx], modulo 2^32 (wraps silently).
    - Pipeline en[idx] into a tag alongside the LUT read.
    - After idx=N-1, go to DRAIN.
  - DRAIN (1 cycle): go to DONE.
  - Accumulation: in the cycle after each ISSUE cycle, add the sign-extended amplitude to the OUT_W accumulator if the tag is 1; add 0 if the tag is 0.
  - DONE (1 cycle): sample_out <= accumulator; sample_valid_out=1; go to IDLE.
- Timing: step_in sampled at cycle t gives sample_valid_out high at cycle t+N+3. busy_out is high from t+1 through t+N+3.
- Disabled voices contribute 0 and keep their phase frozen.
- step_in while busy_out=1 (including the DONE cycle) is ignored and sets overrun_out=1. overrun_out clears only on reset.
- Config writes:
  - Applied at the clock edge when cfg_we_in=1; legal in any state.
  - If cfg_clr_in=1, phase <= 0, overriding the same-cycle ISSUE increment for that voice.
  - A write to the voice currently in ISSUE: the phase update in that cycle uses the old incr and old en; the new values take effect from the next tick.
- sample_out holds its value between valid pulses.

Test Plan:
- Reset hold: rst_in=0 for 3 cycles with step_in toggling -> all outputs stay 0; no valid pulse.
- Single voice, 750 Hz: voice0 incr=32'h2000_0000, en=1, others off; 7 ticks -> sample_out = 0, 90, 127, 90, 0, -91, -128; each valid pulse comes exactly N+3 cycles after its step_in.
- Two-voice sum: voices 0 and 1 with incr=32'h4000_0000, en=1; 4 ticks -> sample_out = 0, 254, 0, -256.
- Overrun and disable: a second step_in 2 cycles after the first -> only one valid pulse and overrun_out=1. With all voices disabled, a tick gives sample_out=0 and phases unchanged.
- Config collision: write voice0 with cfg_clr_in=1 during its ISSUE cycle -> its phase reads 0 afterward, and the next tick's voice0 term is 0 (LUT index 0).
- Wrap: voice0 incr=32'hFFFF_FFFF, phase at 0; after 2 ticks -> phase = 32'hFFFF_FFFE with no error; LUT indices 0 then 63 give amplitudes 0 then -13.
